pipeline_hazard_unit: RTL

- Hazard and forwarding controller for the 5-stage 8-bit pipeline (IF, ID, EX, MEM, WB).
- Keeps a shadow scoreboard of the instructions in EX, MEM and WB.
- Drives the PC/PR1 hold, the PR2 bubble, the PR1 flush on ID-resolved redirects, the EX-stage operand forwarding selects and the ID-stage write-back bypass.
- Counts stall cycles for performance debug.

---
 rtl/pipeline_hazard_unit_if.sv | 41 ++++
 rtl/pipeline_hazard_unit.sv | 106 ++++++++++
 2 files changed

// File: rtl/pipeline_hazard_unit_if.sv
// Bundle between the ID-stage decode fields and the hazard/forwarding controls.
// The master drives the decoded instruction; the slave (hazard unit) returns the controls.
interface pipeline_hazard_unit_if #(
   parameter int REG_ID_LEN = 3,
   parameter int CNT_LEN    = 16
);
   logic                  id_valid;
   logic [REG_ID_LEN-1:0] id_rs1;
   logic [REG_ID_LEN-1:0] id_rs2;
   logic                  id_rs1_used;
   logic                  id_rs2_used;
   logic [REG_ID_LEN-1:0] id_rd;
   logic                  id_wr_en;
   logic                  id_is_load;
   logic                  id_sets_flags;
   logic                  id_uses_flags;
   logic                  id_redirect;

   logic                  stall_if;
   logic                  bubble_ex;
   logic                  flush_if;
   logic [1:0]            fwd_sel1_ex;
   logic [1:0]            fwd_sel2_ex;
   logic                  id_bypass1;
   logic                  id_bypass2;
   logic [CNT_LEN-1:0]    stall_cnt;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
             id_wr_en, id_is_load, id_sets_flags, id_uses_flags, id_redirect,
      input  stall_if, bubble_ex, flush_if, fwd_sel1_ex, fwd_sel2_ex,
             id_bypass1, id_bypass2, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
             id_wr_en, id_is_load, id_sets_flags, id_uses_flags, id_redirect,
      output stall_if, bubble_ex, flush_if, fwd_sel1_ex, fwd_sel2_ex,
             id_bypass1, id_bypass2, stall_cnt
   );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline: shadow scoreboard of
// EX/MEM/WB, load-use and flag stalls, ID redirect flush, EX forwarding, WB bypass.
module pipeline_hazard_unit #(
   parameter int REG_ID_LEN = 3,
   parameter int CNT_LEN    = 16
) (
   input logic               clk,
   input logic               rst,
   pipeline_hazard_unit_if.slave hz
);

   typedef struct packed {
      logic                  valid;
      logic [REG_ID_LEN-1:0] rd;
      logic                  wr_en;
      logic                  is_load;
      logic                  sets_flags;
   } entry_t;

   entry_t             s_ex;
   entry_t             s_mem;
   entry_t             s_wb;
   entry_t             s_ex_d;
   logic [1:0]         sel1_q;
   logic [1:0]         sel2_q;
   logic [1:0]         sel1_d;
   logic [1:0]         sel2_d;
   logic [CNT_LEN-1:0] cnt_q;

   logic m_ex1, m_ex2, m_mem1, m_mem2, m_wb1, m_wb2;
   logic load_use, flag_stall, stall, flush, advance;

   function automatic logic match(input entry_t e, input logic [REG_ID_LEN-1:0] r);
      return e.valid && e.wr_en && (e.rd == r);
   endfunction

   assign m_ex1  = hz.id_rs1_used && match(s_ex,  hz.id_rs1);
   assign m_ex2  = hz.id_rs2_used && match(s_ex,  hz.id_rs2);
   assign m_mem1 = hz.id_rs1_used && match(s_mem, hz.id_rs1);
   assign m_mem2 = hz.id_rs2_used && match(s_mem, hz.id_rs2);
   assign m_wb1  = hz.id_rs1_used && match(s_wb,  hz.id_rs1);
   assign m_wb2  = hz.id_rs2_used && match(s_wb,  hz.id_rs2);

   assign load_use   = hz.id_valid && s_ex.is_load && (m_ex1 || m_ex2);
   assign flag_stall = hz.id_valid && hz.id_uses_flags && s_ex.valid && s_ex.sets_flags;
   assign stall      = load_use || flag_stall;
   // A stalled branch must not redirect yet; it is re-evaluated next cycle.
   assign flush      = hz.id_redirect && hz.id_valid && !stall;
   assign advance    = hz.id_valid && !stall && !flush;

   assign hz.stall_if    = stall;
   assign hz.bubble_ex   = stall;
   assign hz.flush_if    = flush;
   assign hz.id_bypass1  = hz.id_valid && m_wb1;
   assign hz.id_bypass2  = hz.id_valid && m_wb2;
   assign hz.fwd_sel1_ex = sel1_q;
   assign hz.fwd_sel2_ex = sel2_q;
   assign hz.stall_cnt   = cnt_q;

   always_comb begin
      s_ex_d = '0;
      if (advance) begin
         s_ex_d.valid      = 1'b1;
         s_ex_d.rd         = hz.id_rd;
         s_ex_d.wr_en      = hz.id_wr_en;
         s_ex_d.is_load    = hz.id_is_load;
         s_ex_d.sets_flags = hz.id_sets_flags;
      end
   end

   // Youngest producer wins; a load in EX cannot forward (that case stalls instead).
   always_comb begin
      sel1_d = 2'd0;
      sel2_d = 2'd0;
      if (advance) begin
         if (m_ex1 && !s_ex.is_load)      sel1_d = 2'd1;
         else if (m_mem1)                 sel1_d = 2'd2;
         if (m_ex2 && !s_ex.is_load)      sel2_d = 2'd1;
         else if (m_mem2)                 sel2_d = 2'd2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_ex   <= '0;
         s_mem  <= '0;
         s_wb   <= '0;
         sel1_q <= 2'd0;
         sel2_q <= 2'd0;
      end else begin
         s_ex   <= s_ex_d;
         s_mem  <= s_ex;
         s_wb   <= s_mem;
         sel1_q <= sel1_d;
         sel2_q <= sel2_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else if (stall && (cnt_q != {CNT_LEN{1'b1}}))
         cnt_q <= cnt_q + CNT_LEN'(1);
   end

endmodule
